// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with valid/ready handshake and synchronous flush.
// Sustains one transfer per cycle in both directions; out_data always comes straight from the main register.
module pipe_skid_reg #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // State encoding doubles as the entry count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]       state_r;
   logic [1:0]       state_nx_s;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] main_nx_s;
   logic [WIDTH-1:0] skid_r;
   logic [WIDTH-1:0] skid_nx_s;
   logic             in_fire_s;
   logic             out_fire_s;

   assign in_ready   = (state_r != ST_TWO) & ~flush;
   assign out_valid  = (state_r != ST_EMPTY);
   assign out_data   = main_r;
   assign occupancy  = state_r;
   assign in_fire_s  = in_valid & in_ready;
   assign out_fire_s = out_valid & out_ready;

   // Next-state and storage update; flush overrides every transfer.
   always_comb begin
      state_nx_s = state_r;
      main_nx_s  = main_r;
      skid_nx_s  = skid_r;
      if (flush) begin
         state_nx_s = ST_EMPTY;
         main_nx_s  = RESET_VAL;
         skid_nx_s  = RESET_VAL;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nx_s = ST_ONE;
                  main_nx_s  = in_data;
               end else begin
                  state_nx_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  state_nx_s = ST_ONE;
                  main_nx_s  = in_data;
               end else if (in_fire_s) begin
                  state_nx_s = ST_TWO;
                  skid_nx_s  = in_data;
               end else if (out_fire_s) begin
                  state_nx_s = ST_EMPTY;
               end else begin
                  state_nx_s = ST_ONE;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only the downstream side can move.
               if (out_fire_s) begin
                  state_nx_s = ST_ONE;
                  main_nx_s  = skid_r;
                  skid_nx_s  = RESET_VAL;
               end else begin
                  state_nx_s = ST_TWO;
               end
            end
            default: begin
               state_nx_s = ST_EMPTY;
               main_nx_s  = RESET_VAL;
               skid_nx_s  = RESET_VAL;
            end
         endcase
      end
   end

   // State and payload registers, cleared immediately by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_EMPTY;
         main_r  <= RESET_VAL;
         skid_r  <= RESET_VAL;
      end else begin
         state_r <= state_nx_s;
         main_r  <= main_nx_s;
         skid_r  <= skid_nx_s;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed sequences, a vector table and
// a randomized run checked against a queue-based reference model.
module tb_pipe_skid_reg;

   localparam logic [7:0] RV = 8'h3C;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] occupancy;

   int n_checks;
   int n_fail;

   // Reference model: FIFO contents plus what out_data shows when empty.
   logic [7:0] mq[$];
   logic [7:0] last_out;

   typedef struct packed {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      logic       e_rdy;
      logic       e_val;
      logic [7:0] e_data;
      logic [1:0] e_occ;
   } vec_t;

   vec_t tbl[$];

   pipe_skid_reg #(.WIDTH(8), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      mq.delete();
      last_out = RV;
   endtask

   function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                               input logic e_rdy, input logic e_val, input logic [7:0] e_data,
                               input logic [1:0] e_occ);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
      v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_occ = e_occ;
      return v;
   endfunction

   // One model-checked cycle: compare outputs with the model, clock, update the model.
   task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      logic inf;
      logic outf;
      int   sz;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      sz = mq.size();
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, (sz < 2) && !fl});
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
      chk("rnd_occupancy", {30'd0, occupancy}, sz);
      chk("rnd_out_data", {24'd0, out_data}, {24'd0, (sz != 0) ? mq[0] : last_out});
      inf  = iv && (sz < 2) && !fl;
      outf = ordy && (sz != 0);
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
         last_out = RV;
      end else begin
         if (outf) last_out = mq.pop_front();
         if (inf) mq.push_back(d);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      last_out = RV;

      // Reset asserted while upstream is offering data.
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h77;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", {24'd0, out_data}, {24'd0, RV});
      rst     = 1'b0;
      in_data = 8'hA5;
      tick();
      chk("first_out_valid", {31'd0, out_valid}, 32'd1);
      chk("first_out_data", {24'd0, out_data}, 32'h0000_00A5);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("first_drain", {31'd0, out_valid}, 32'd0);

      // Back-to-back stream with the sink always ready.
      for (int i = 0; i <= 16; i++) begin
         in_valid  = (i < 16);
         in_data   = i[7:0];
         out_ready = 1'b1;
         tick();
         if (i < 16) begin
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_data", {24'd0, out_data}, i);
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
         end
      end
      chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

      // Vector table: backpressure fill/drain, then flush from TWO and from ONE.
      do_reset();
      tbl.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1));
      tbl.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2));
      tbl.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2));
      tbl.push_back(mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd1));
      tbl.push_back(mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 2'd0));
      tbl.push_back(mk(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1));
      tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 2'd2));
      tbl.push_back(mk(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, RV,    2'd0));
      tbl.push_back(mk(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 2'd1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h66, 2'd0));
      tbl.push_back(mk(1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88, 2'd1));
      tbl.push_back(mk(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, RV,    2'd0));
      foreach (tbl[k]) begin
         in_valid  = tbl[k].iv;
         in_data   = tbl[k].d;
         out_ready = tbl[k].ordy;
         flush     = tbl[k].fl;
         tick();
         chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].e_rdy});
         chk($sformatf("vec%0d_out_valid", k), {31'd0, out_valid}, {31'd0, tbl[k].e_val});
         chk($sformatf("vec%0d_out_data", k), {24'd0, out_data}, {24'd0, tbl[k].e_data});
         chk($sformatf("vec%0d_occupancy", k), {30'd0, occupancy}, {30'd0, tbl[k].e_occ});
      end
      flush = 1'b0;

      // Asynchronous reset pulse between edges while full.
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'h12;
      tick();
      in_data = 8'h34;
      tick();
      chk("async_pre_occ", {30'd0, occupancy}, 32'd2);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_occupancy", {30'd0, occupancy}, 32'd0);
      chk("async_out_data", {24'd0, out_data}, {24'd0, RV});
      chk("async_in_ready", {31'd0, in_ready}, 32'd1);
      #2;
      rst = 1'b0;
      tick();
      chk("async_post_occ", {30'd0, occupancy}, 32'd0);

      // Randomized traffic against the queue model.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 31) == 0);
      end
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
